// File: rtl/sid_pwm_dac.sv
// Audio output stage: double-buffers signed filter samples, converts them to an
// offset-binary PWM duty (optionally error-feedback shaped) and drives one PWM bit.
module sid_pwm_dac #(
  parameter int IN_W  = 12,
  parameter int PWM_W = 8,
  parameter int SHAPE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IN_W-1:0] sample_in,
  input  logic            sample_valid,
  output logic            sample_ready,
  output logic            pwm_out,
  output logic            period_start,
  output logic            underrun
);

  localparam int               ERR_W    = IN_W - PWM_W;
  localparam logic [PWM_W-1:0] CNT_LAST = {PWM_W{1'b1}};
  localparam logic [PWM_W-1:0] DUTY_MID = {1'b1, {(PWM_W-1){1'b0}}};

  logic [PWM_W-1:0] r_cnt;
  logic [PWM_W-1:0] r_duty;
  logic [ERR_W-1:0] r_err;
  logic [IN_W-1:0]  r_hold;
  logic             r_full;
  logic             r_miss;
  logic             r_pwm;
  logic             r_pstart;
  logic             r_under;

  logic [IN_W-1:0]  w_u;
  logic [PWM_W-1:0] w_duty_next;
  logic [ERR_W-1:0] w_err_next;
  logic             w_accept;
  logic             w_load;

  assign sample_ready = !r_full && !rst;
  assign w_accept     = sample_valid && sample_ready;
  assign w_load       = (r_cnt == CNT_LAST);

  // Inverting the sign bit maps two's complement onto offset binary.
  assign w_u = {~r_hold[IN_W-1], r_hold[IN_W-2:0]};

  generate
    if (SHAPE != 0) begin : g_shape
      logic [IN_W:0]   w_acc;
      logic [IN_W-1:0] w_acc_sat;

      // Saturate rather than wrap so full-scale plus residue stays full-scale.
      assign w_acc       = {1'b0, w_u} + {{(PWM_W+1){1'b0}}, r_err};
      assign w_acc_sat   = w_acc[IN_W] ? {IN_W{1'b1}} : w_acc[IN_W-1:0];
      assign w_duty_next = w_acc_sat[IN_W-1 -: PWM_W];
      assign w_err_next  = w_acc_sat[ERR_W-1:0];
    end else begin : g_trunc
      assign w_duty_next = w_u[IN_W-1 -: PWM_W];
      assign w_err_next  = '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_hold <= '0;
      r_full <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (w_accept) begin
        r_hold <= sample_in;
        r_full <= 1'b1;
      end else if (w_load) begin
        r_full <= 1'b0;
      end
    end
  end

  // Duty and residue only move at the end of a period; an empty buffer holds both.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_duty <= DUTY_MID;
      r_err  <= '0;
      r_miss <= 1'b1;
    end else if (w_load) begin
      r_miss <= !r_full;
      if (r_full) begin
        r_duty <= w_duty_next;
        r_err  <= w_err_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwm    <= 1'b0;
      r_pstart <= 1'b0;
      r_under  <= 1'b0;
    end else begin
      r_pwm    <= (r_cnt < r_duty);
      r_pstart <= (r_cnt == '0);
      r_under  <= (r_cnt == '0) && r_miss;
    end
  end

  assign pwm_out      = r_pwm;
  assign period_start = r_pstart;
  assign underrun     = r_under;

endmodule

// File: tb/tb_sid_pwm_dac.sv
// Directed bench for sid_pwm_dac: one truncating instance and one noise-shaping
// instance share clock and reset; expected duties are hand-computed.
module tb_sid_pwm_dac;
  localparam int IN_W  = 12;
  localparam int PWM_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [IN_W-1:0] sin0 = '0, sin1 = '0;
  logic val0 = 1'b0, val1 = 1'b0;
  logic rdy0, rdy1, pwm0, pwm1, ps0, ps1, ur0, ur1;

  logic [IN_W-1:0] fq0[$];
  logic [IN_W-1:0] fq1[$];
  bit pend0, pend1;
  int acc_step0, acc_step1;
  int cyc;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sid_pwm_dac #(.IN_W(IN_W), .PWM_W(PWM_W), .SHAPE(0)) u_dut0 (
    .clk(clk), .rst(rst), .sample_in(sin0), .sample_valid(val0),
    .sample_ready(rdy0), .pwm_out(pwm0), .period_start(ps0), .underrun(ur0)
  );

  sid_pwm_dac #(.IN_W(IN_W), .PWM_W(PWM_W), .SHAPE(1)) u_dut1 (
    .clk(clk), .rst(rst), .sample_in(sin1), .sample_valid(val1),
    .sample_ready(rdy1), .pwm_out(pwm1), .period_start(ps1), .underrun(ur1)
  );

  task automatic drive_inputs();
    if (fq0.size() > 0) begin sin0 = fq0[0]; val0 = 1'b1; end
    else val0 = 1'b0;
    if (fq1.size() > 0) begin sin1 = fq1[0]; val1 = 1'b1; end
    else val1 = 1'b0;
    pend0 = val0 && rdy0;
    pend1 = val1 && rdy1;
    if (pend0) acc_step0 = cyc;
    if (pend1) acc_step1 = cyc;
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (pend0) void'(fq0.pop_front());
    if (pend1) void'(fq1.pop_front());
    drive_inputs();
  endtask

  task automatic run_period(output int hi0, output int hi1, output bit u0,
                            output bit u1, output int rdyc0);
    hi0 = 0; hi1 = 0; rdyc0 = 0;
    u0 = ur0; u1 = ur1;
    for (int i = 0; i < 256; i++) begin
      if (pwm0) hi0++;
      if (pwm1) hi1++;
      if (rdy0) rdyc0++;
      step();
    end
  endtask

  task automatic sync_ps(output bit ok);
    int n = 0;
    while (!ps0 && n < 300) begin step(); n++; end
    ok = ps0;
  endtask

  task automatic test_reset();
    int h0, h1, rc; bit u0, u1, ok;
    rst = 1'b1;
    repeat (3) begin
      step();
      tests++;
      if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin
        fails++; $display("FAIL reset_ready: got %b/%b expected 0/0", rdy0, rdy1);
      end
      tests++;
      if ({pwm0, ps0, ur0, pwm1, ps1, ur1} !== 6'b0) begin
        fails++; $display("FAIL reset_outputs: got %b expected 000000", {pwm0, ps0, ur0, pwm1, ps1, ur1});
      end
    end
    rst = 1'b0;
    step();
    tests++;
    if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin
      fails++; $display("FAIL release_ready: got %b/%b expected 1/1", rdy0, rdy1);
    end
    sync_ps(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL first_period_start: got 0 expected 1"); end
    for (int p = 0; p < 3; p++) begin
      run_period(h0, h1, u0, u1, rc);
      tests++;
      if (h0 !== 128 || h1 !== 128) begin
        fails++; $display("FAIL idle_high p%0d: got %0d/%0d expected 128/128", p, h0, h1);
      end
      if (p > 0) begin
        tests++;
        if (u0 !== 1'b1 || u1 !== 1'b1) begin
          fails++; $display("FAIL idle_underrun p%0d: got %b/%b expected 1/1", p, u0, u1);
        end
      end
      tests++;
      if (ps0 !== 1'b1 || ps1 !== 1'b1) begin
        fails++; $display("FAIL period_align p%0d: got %b/%b expected 1/1", p, ps0, ps1);
      end
    end
  endtask

  task automatic test_transfer();
    logic [IN_W-1:0] vec[4];
    int exp_hi[4];
    int prev, h0, h1, rc; bit u0, u1;
    vec = '{12'h7FF, 12'h800, 12'h3FF, 12'h000};
    exp_hi = '{255, 0, 191, 128};
    prev = 128;
    for (int i = 0; i < 4; i++) begin
      fq0.push_back(vec[i]);
      drive_inputs();
      run_period(h0, h1, u0, u1, rc);
      tests++;
      if (h0 !== prev) begin
        fails++; $display("FAIL xfer_latency %h: got %0d expected %0d", vec[i], h0, prev);
      end
      run_period(h0, h1, u0, u1, rc);
      tests++;
      if (h0 !== exp_hi[i]) begin
        fails++; $display("FAIL xfer_high %h: got %0d expected %0d", vec[i], h0, exp_hi[i]);
      end
      tests++;
      if (u0 !== 1'b0) begin
        fails++; $display("FAIL xfer_underrun %h: got %b expected 0", vec[i], u0);
      end
      prev = exp_hi[i];
    end
  endtask

  task automatic test_back_to_back();
    int c0, h0, h1, rc; bit u0, u1;
    c0 = cyc;
    fq0.push_back(12'h7FF);
    fq0.push_back(12'h800);
    drive_inputs();
    tests++;
    if (!pend0 || acc_step0 !== c0) begin
      fails++; $display("FAIL b2b_first_accept: got step %0d expected %0d", acc_step0, c0);
    end
    run_period(h0, h1, u0, u1, rc);
    tests++;
    if (rc !== 2) begin
      fails++; $display("FAIL b2b_ready_cycles: got %0d expected 2", rc);
    end
    tests++;
    if (acc_step0 !== c0 + 255) begin
      fails++; $display("FAIL b2b_second_accept: got step %0d expected %0d", acc_step0, c0 + 255);
    end
    tests++;
    if (h0 !== 128) begin
      fails++; $display("FAIL b2b_old_duty: got %0d expected 128", h0);
    end
    run_period(h0, h1, u0, u1, rc);
    tests++;
    if (h0 !== 255 || u0 !== 1'b0) begin
      fails++; $display("FAIL b2b_first_out: got %0d ur %b expected 255 ur 0", h0, u0);
    end
    run_period(h0, h1, u0, u1, rc);
    tests++;
    if (h0 !== 0 || u0 !== 1'b0) begin
      fails++; $display("FAIL b2b_second_out: got %0d ur %b expected 0 ur 0", h0, u0);
    end
  endtask

  task automatic test_noise_shaping();
    int total, h0, h1, rc, e; bit u0, u1;
    total = 0;
    for (int i = 0; i <= 16; i++) begin
      fq1.push_back(12'h008);
      drive_inputs();
      run_period(h0, h1, u0, u1, rc);
      if (i > 0) begin
        e = (i % 2 == 1) ? 128 : 129;
        total += h1;
        tests++;
        if (h1 !== e || u1 !== 1'b0) begin
          fails++; $display("FAIL shape_period %0d: got %0d ur %b expected %0d ur 0", i, h1, u1, e);
        end
      end
    end
    tests++;
    if (total !== 2056) begin
      fails++; $display("FAIL shape_total: got %0d expected 2056", total);
    end
    // residue is 8 here, so full scale overflows and must saturate
    fq1.push_back(12'h7FF);
    drive_inputs();
    run_period(h0, h1, u0, u1, rc);
    tests++;
    if (h1 !== 128) begin
      fails++; $display("FAIL sat_prev: got %0d expected 128", h1);
    end
    run_period(h0, h1, u0, u1, rc);
    tests++;
    if (h1 !== 255) begin
      fails++; $display("FAIL sat_high: got %0d expected 255", h1);
    end
    run_period(h0, h1, u0, u1, rc);
    tests++;
    if (h1 !== 255 || u1 !== 1'b1) begin
      fails++; $display("FAIL sat_hold: got %0d ur %b expected 255 ur 1", h1, u1);
    end
  endtask

  task automatic test_reset_mid();
    int h0, h1, rc; bit u0, u1, ok;
    fq0.push_back(12'h7FF);
    fq1.push_back(12'h7FF);
    drive_inputs();
    repeat (99) step();
    tests++;
    if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin
      fails++; $display("FAIL mid_full: got ready %b/%b expected 0/0", rdy0, rdy1);
    end
    rst = 1'b1;
    repeat (3) step();
    tests++;
    if (rdy0 !== 1'b0 || pwm0 !== 1'b0 || pwm1 !== 1'b0) begin
      fails++; $display("FAIL mid_in_reset: got rdy %b pwm %b/%b expected 0 0/0", rdy0, pwm0, pwm1);
    end
    rst = 1'b0;
    step();
    tests++;
    if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin
      fails++; $display("FAIL mid_release_ready: got %b/%b expected 1/1", rdy0, rdy1);
    end
    sync_ps(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL mid_period_start: got 0 expected 1"); end
    for (int p = 0; p < 2; p++) begin
      run_period(h0, h1, u0, u1, rc);
      tests++;
      if (h0 !== 128 || h1 !== 128) begin
        fails++; $display("FAIL mid_after p%0d: got %0d/%0d expected 128/128", p, h0, h1);
      end
    end
  endtask

  task automatic test_underrun_hold();
    int h0, h1, rc; bit u0, u1;
    fq1.push_back(12'h3FF);
    drive_inputs();
    run_period(h0, h1, u0, u1, rc);
    run_period(h0, h1, u0, u1, rc);
    tests++;
    if (h1 !== 191 || u1 !== 1'b0) begin
      fails++; $display("FAIL hold_load: got %0d ur %b expected 191 ur 0", h1, u1);
    end
    for (int p = 0; p < 3; p++) begin
      run_period(h0, h1, u0, u1, rc);
      tests++;
      if (h1 !== 191 || u1 !== 1'b1) begin
        fails++; $display("FAIL hold_period p%0d: got %0d ur %b expected 191 ur 1", p, h1, u1);
      end
    end
    // retained residue 0xF pushes 0xBFF up to 0xC0E
    fq1.push_back(12'h3FF);
    drive_inputs();
    run_period(h0, h1, u0, u1, rc);
    tests++;
    if (h1 !== 191 || u1 !== 1'b1) begin
      fails++; $display("FAIL hold_resume_prev: got %0d ur %b expected 191 ur 1", h1, u1);
    end
    run_period(h0, h1, u0, u1, rc);
    tests++;
    if (h1 !== 192 || u1 !== 1'b0) begin
      fails++; $display("FAIL hold_resume: got %0d ur %b expected 192 ur 0", h1, u1);
    end
  endtask

  initial begin
    cyc = 0;
    test_reset();
    test_transfer();
    test_back_to_back();
    test_noise_shaping();
    test_reset_mid();
    test_underrun_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
